// File: rtl/sine_wave_analyzer.sv
// Measures period, peaks and peak-to-peak amplitude of an offset-binary sine on the wave bus.
// Define SINE_WAVE_ANALYZER_AVG_EN to report the mean of the last four raw periods.
module sine_wave_analyzer #(
  parameter logic [7:0]    MID        = 8'd127,
  parameter logic [7:0]    HYST       = 8'd4,
  parameter int unsigned   PW         = 16,
  parameter logic [PW-1:0] MAX_PERIOD = {PW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [7:0]    wave,
  output logic [PW-1:0] period,
  output logic [7:0]    peak_max,
  output logic [7:0]    peak_min,
  output logic [7:0]    amplitude,
  output logic          meas_valid,
  output logic          locked
);

  localparam logic [7:0] HI_TH = MID + HYST;
  localparam logic [7:0] LO_TH = MID - HYST;

  localparam logic [1:0] StSeek = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          first_seen_q, first_seen_d;
  logic [7:0]    run_max_q, run_max_d;
  logic [7:0]    run_min_q, run_min_d;
  logic [PW-1:0] period_q, period_d;
  logic [7:0]    peak_max_q, peak_max_d;
  logic [7:0]    peak_min_q, peak_min_d;
  logic [7:0]    amplitude_q, amplitude_d;
  logic          meas_valid_q, meas_valid_d;
  logic          locked_q, locked_d;

  logic          is_low, is_high, crossing, timeout, measure;
  logic [PW:0]   cnt_inc;

`ifdef SINE_WAVE_ANALYZER_AVG_EN
  logic [2:0][PW-1:0] hist_q, hist_d;
  logic [1:0]         hist_cnt_q, hist_cnt_d;
  logic [PW+1:0]      hist_sum;
`endif

  always_comb begin
    cnt_inc  = {1'b0, cnt_q} + {{PW{1'b0}}, 1'b1};
    is_low   = (wave <= LO_TH);
    is_high  = (wave >= HI_TH);
    crossing = sample_en && (state_q == StLow) && is_high;
    // Timeout wins over a crossing on the same sample.
    timeout  = sample_en && first_seen_q && (cnt_inc >= {1'b0, MAX_PERIOD});
    measure  = crossing && first_seen_q && !timeout;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    first_seen_d = first_seen_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    locked_d     = locked_q;
    if (sample_en) begin
      case (state_q)
        StSeek:  if (is_low)  state_d = StLow;
        StLow:   if (is_high) state_d = StHigh;
        StHigh:  if (is_low)  state_d = StLow;
        default: state_d = StSeek;
      endcase
      if (timeout) begin
        state_d      = StSeek;
        first_seen_d = 1'b0;
        locked_d     = 1'b0;
        cnt_d        = '0;
        run_max_d    = 8'h00;
        run_min_d    = 8'hFF;
      end else if (crossing) begin
        first_seen_d = 1'b1;
        cnt_d        = '0;
        run_max_d    = wave;
        run_min_d    = wave;
      end else begin
        cnt_d = (cnt_inc >= {1'b0, MAX_PERIOD}) ? MAX_PERIOD : cnt_inc[PW-1:0];
        if (wave > run_max_q) run_max_d = wave;
        if (wave < run_min_q) run_min_d = wave;
      end
    end
`ifndef SINE_WAVE_ANALYZER_AVG_EN
    if (measure) locked_d = 1'b1;
`else
    if (measure && (hist_cnt_q == 2'd3)) locked_d = 1'b1;
`endif
  end

  // Published measurement set.
  always_comb begin
    period_d     = period_q;
    peak_max_d   = peak_max_q;
    peak_min_d   = peak_min_q;
    amplitude_d  = amplitude_q;
    meas_valid_d = 1'b0;
`ifndef SINE_WAVE_ANALYZER_AVG_EN
    if (measure) begin
      period_d     = cnt_inc[PW-1:0];
      peak_max_d   = run_max_q;
      peak_min_d   = run_min_q;
      amplitude_d  = run_max_q - run_min_q;
      meas_valid_d = 1'b1;
    end
`else
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    hist_sum   = (PW+2)'(hist_q[0]) + (PW+2)'(hist_q[1]) + (PW+2)'(hist_q[2]) +
                 (PW+2)'(cnt_inc[PW-1:0]);
    if (timeout) begin
      hist_d     = '0;
      hist_cnt_d = 2'd0;
    end else if (measure) begin
      hist_d      = {hist_q[1:0], cnt_inc[PW-1:0]};
      peak_max_d  = run_max_q;
      peak_min_d  = run_min_q;
      amplitude_d = run_max_q - run_min_q;
      if (hist_cnt_q == 2'd3) begin
        period_d     = hist_sum[PW+1:2];
        meas_valid_d = 1'b1;
      end else begin
        hist_cnt_d = hist_cnt_q + 2'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StSeek;
      cnt_q        <= '0;
      first_seen_q <= 1'b0;
      run_max_q    <= 8'h00;
      run_min_q    <= 8'hFF;
      period_q     <= '0;
      peak_max_q   <= 8'h00;
      peak_min_q   <= 8'h00;
      amplitude_q  <= 8'h00;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
`ifdef SINE_WAVE_ANALYZER_AVG_EN
      hist_q       <= '0;
      hist_cnt_q   <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_seen_q <= first_seen_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      period_q     <= period_d;
      peak_max_q   <= peak_max_d;
      peak_min_q   <= peak_min_d;
      amplitude_q  <= amplitude_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
`ifdef SINE_WAVE_ANALYZER_AVG_EN
      hist_q       <= hist_d;
      hist_cnt_q   <= hist_cnt_d;
`endif
    end
  end

  assign period     = period_q;
  assign peak_max   = peak_max_q;
  assign peak_min   = peak_min_q;
  assign amplitude  = amplitude_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// Scoreboard bench for sine_wave_analyzer: index-based crossing model feeds an expectation queue.
module tb_sine_wave_analyzer;

  localparam int MAXP = 300;
  localparam int LO   = 123;
  localparam int HI   = 131;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [7:0]  wave = 8'd0;
  logic [15:0] period;
  logic [7:0]  peak_max, peak_min, amplitude;
  logic        meas_valid, locked;

  sine_wave_analyzer #(.MAX_PERIOD(16'd300)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .wave       (wave),
    .period     (period),
    .peak_max   (peak_max),
    .peak_min   (peak_min),
    .amplitude  (amplitude),
    .meas_valid (meas_valid),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int mx;
    int mn;
    int amp;
  } meas_t;

  meas_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    n_pop = 0;
  int    long_pulses = 0;
  bit    prev_valid = 1'b0;

  // Reference model: every accepted sample is kept; crossings are sample indices.
  int acc[$];
  int cross_idx = 0;
  bit have_cross = 1'b0;
  int last_oob = -1;  // -1 unknown (seeking), 0 last out-of-band was low, 1 high
  bit m_locked = 1'b0;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    have_cross = 1'b0;
    last_oob   = -1;
    m_locked   = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(int w);
    int    i;
    bit    rising;
    meas_t m;
    i = acc.size();
    acc.push_back(w);
    rising = (w >= HI) && (last_oob == 0);
    if (w <= LO) last_oob = 0;
    else if (w >= HI) last_oob = 1;
    if (have_cross && (i - cross_idx >= MAXP)) begin
      have_cross = 1'b0;
      last_oob   = -1;
      m_locked   = 1'b0;
    end else if (rising) begin
      if (have_cross) begin
        m.per = i - cross_idx;
        m.mx  = 0;
        m.mn  = 255;
        for (int j = cross_idx; j < i; j++) begin
          if (acc[j] > m.mx) m.mx = acc[j];
          if (acc[j] < m.mn) m.mn = acc[j];
        end
        m.amp = m.mx - m.mn;
        exp_q.push_back(m);
        m_locked = 1'b1;
      end
      have_cross = 1'b1;
      cross_idx  = i;
    end
  endfunction

  // Monitor: pops one expectation per meas_valid cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("locked_track", int'(locked), int'(m_locked));
      if (meas_valid) begin
        if (prev_valid) long_pulses++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_meas_valid: got pulse, expected none (period=%0d)", period);
        end else begin
          meas_t e;
          e = exp_q.pop_front();
          n_pop++;
          check("period", int'(period), e.per);
          check("peak_max", int'(peak_max), e.mx);
          check("peak_min", int'(peak_min), e.mn);
          check("amplitude", int'(amplitude), e.amp);
        end
      end
      prev_valid = meas_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic put(input bit en, input logic [7:0] w);
    sample_en = en;
    wave      = w;
    @(posedge clk);
    if (en) model_accept(int'(w));
    #1;
  endtask

  task automatic do_reset();
    sample_en = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_period", int'(period), 0);
    check("rst_peak_max", int'(peak_max), 0);
    check("rst_peak_min", int'(peak_min), 0);
    check("rst_amplitude", int'(amplitude), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sq(int k);
    return ((k % 100) < 50) ? 8'd50 : 8'd200;
  endfunction

  task automatic run_random();
    int h, cyc, duty, v;
    for (int b = 0; b < 15; b++) begin
      h    = $urandom_range(1, 160);
      cyc  = $urandom_range(2, 4);
      duty = $urandom_range(0, 2);
      for (int c = 0; c < cyc; c++) begin
        for (int s = 0; s < 2 * h; s++) begin
          if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 255);
          else if (s < h) v = $urandom_range(0, LO);
          else v = $urandom_range(HI, 255);
          if (duty != 0) repeat ($urandom_range(0, duty)) put(1'b0, 8'($urandom_range(0, 255)));
          put(1'b1, 8'(v));
        end
      end
    end
    // Shortest measurable period, continuous enable: back-to-back pulses.
    for (int i = 0; i < 40; i++) put(1'b1, (i % 2 == 1) ? 8'd255 : 8'd0);
  endtask

  initial begin
    int np;
    #3;
    do_reset();

    // Square-wave lock, continuous enable.
    for (int k = 0; k < 150; k++) put(1'b1, sq(k));
    check("sq_pulses_before_2nd_crossing", n_pop, 0);
    check("sq_locked_before", int'(locked), 0);
    put(1'b1, sq(150));
    check("sq_meas_valid", int'(meas_valid), 1);
    check("sq_period", int'(period), 100);
    check("sq_peak_max", int'(peak_max), 200);
    check("sq_peak_min", int'(peak_min), 50);
    check("sq_amplitude", int'(amplitude), 150);
    check("sq_locked", int'(locked), 1);
    for (int k = 151; k < 400; k++) put(1'b1, sq(k));

    // Hysteresis: in-band toggling never crosses.
    do_reset();
    np = n_pop;
    for (int i = 0; i < 1000; i++) put(1'b1, (i % 2 == 1) ? 8'd128 : 8'd126);
    check("hyst_pulses", n_pop - np, 0);
    check("hyst_locked", int'(locked), 0);

    // Sample gating: enable every 4th clock, garbage on idle clocks.
    do_reset();
    long_pulses = 0;
    np = n_pop;
    for (int k = 0; k < 450; k++) begin
      put(1'b1, sq(k));
      repeat (3) put(1'b0, 8'($urandom_range(0, 255)));
    end
    check("gated_period", int'(period), 100);
    check("gated_pulses", n_pop - np, 3);
    check("gated_pulse_width", long_pulses, 0);

    // Timeout after lock.
    do_reset();
    for (int k = 0; k < 250; k++) put(1'b1, sq(k));
    put(1'b1, 8'd200);
    repeat (299) put(1'b1, 8'd200);
    check("timeout_locked_before", int'(locked), 1);
    np = n_pop;
    put(1'b1, 8'd200);
    check("timeout_locked_after", int'(locked), 0);
    check("timeout_period_held", int'(period), 100);
    @(negedge clk);
    check("timeout_no_pulse", n_pop - np, 0);

    // Reset while in HIGH, then reacquire.
    for (int k = 0; k < 180; k++) put(1'b1, sq(k));
    do_reset();
    np = n_pop;
    for (int k = 0; k < 150; k++) put(1'b1, sq(k));
    check("rst_reacq_no_early_pulse", n_pop - np, 0);
    put(1'b1, sq(150));
    check("rst_reacq_meas_valid", int'(meas_valid), 1);
    check("rst_reacq_period", int'(period), 100);

    run_random();

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sine_wave_analyzer.md
# sine_wave_analyzer

Measures an incoming 8-bit offset-binary sine wave (midscale 127, as produced by the team's sine generator) and reports period, peak values and peak-to-peak amplitude once per cycle of the waveform. It sits at the receive end of the wave bus: it samples `wave` on qualified clock edges, detects rising midscale crossings with hysteresis, and publishes a registered measurement set with a one-cycle valid strobe. It is used for loopback checking of the generator and for on-board frequency/amplitude readout.

## Interface
- `MID`, 127: midscale crossing level (unsigned 8-bit).
- `HYST`, 4: hysteresis half-width; thresholds are `MID+HYST` (high) and `MID-HYST` (low).
- `PW`, 16: width of the period counter and `period` output.
- `MAX_PERIOD`, 16'hFFFF: sample count at which lock is declared lost.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `sample_en` input 1: `wave` is accepted on a rising `clk` edge only when high.
- `wave` input 8: unsigned sample, offset binary.
- `period` output PW: samples between the last two rising crossings.
- `peak_max` output 8: maximum sample over the last measured period.
- `peak_min` output 8: minimum sample over the last measured period.
- `amplitude` output 8: `peak_max - peak_min`.
- `meas_valid` output 1: one-cycle pulse; new measurement on outputs.
- `locked` output 1: high while periodic crossings are being tracked.

## Operation
- All state advances only on accepted samples (`sample_en`=1). Otherwise all registers hold, except that `meas_valid` clears.
- FSM states:
  - SEEK: wait for `wave <= MID-HYST`, then go to LOW.
  - LOW: on `wave >= MID+HYST` a rising crossing occurs; go to HIGH.
  - HIGH: on `wave <= MID-HYST` go to LOW.
  - Samples strictly between the thresholds never change state.
- Crossing handling:
  - First crossing after SEEK: set `first_seen`, clear `cnt` to 0, load running max and min with the crossing sample; no measurement.
  - Later crossing (`first_seen`=1):
    - `period <= cnt+1`.
    - `peak_max`/`peak_min` are loaded from the running extremes, which exclude the current sample.
    - `amplitude <= running_max - running_min`, 8-bit unsigned; it cannot underflow because max ≥ min.
    - `meas_valid` pulses; `locked` sets.
    - `cnt` clears to 0; running extremes reload with the current sample.
- Non-crossing accepted sample: `cnt` increments (saturating at `MAX_PERIOD`), and running extremes update with `wave`.
- Timeout: an accepted sample that would make `cnt` reach `MAX_PERIOD` triggers the following. It overrides a crossing on the same sample.
  - `locked` clears; `first_seen` clears; FSM goes to SEEK.
  - Published outputs keep their last values, and no `meas_valid` is issued.
- Reset values:
  - `period`, `peak_max`, `peak_min`, `amplitude`, `meas_valid`, `locked` = 0.
  - Running max = 0, running min = 8'hFF, `cnt` = 0, `first_seen` = 0, FSM = SEEK.
  - Reset asserted mid-measurement discards the partial period.

## Timing
- All outputs are registered.
- On the edge that accepts a crossing sample, the measurement outputs update and `meas_valid` goes high for exactly the following clock cycle.
- `period` counts samples, not clocks. Crossings at sample indices k and k+N give `period`=N, independent of `sample_en` duty.
- Minimum measurable period is 2 accepted samples, because LOW and HIGH each need one sample.
- Back-to-back `meas_valid` pulses are possible in consecutive cycles only if `sample_en` is continuous and the period is 2.

## Configuration
- `SINE_WAVE_ANALYZER_AVG_EN` defined:
  - `period` reports the truncated mean (sum>>2) of the last four raw periods.
  - `locked` and the first `meas_valid` occur only on the fourth measurement after acquisition.
  - Timeout or reset clears the history.
  - `peak_*` and `amplitude` are unaffected.
- Undefined: `period` is raw; `locked` sets on the first measurement. No averaging logic is synthesized.

## Test plan
- Square-wave lock, `sample_en`=1 continuously.
  - Stimulus: 50 samples of 50, then 50 of 200, repeating.
  - First `meas_valid` at the second rising crossing (sample 150): `period`=100, `peak_max`=200, `peak_min`=50, `amplitude`=150, `locked`=1.
- Hysteresis: `wave` alternating 126/128 for 1000 samples → no `meas_valid`; `locked`=0; FSM stays in SEEK/LOW.
- Sample gating: same pattern as the square-wave test with `sample_en` high every 4th clock → `period`=100; `meas_valid` is exactly one clock wide.
- Timeout: `MAX_PERIOD`=300; after lock, hold `wave`=200 → `locked` falls on the 300th sample after the last crossing; `period` holds 100; no `meas_valid`.
- Reset mid-operation: drop `rst` while in HIGH → all outputs 0 immediately; after release, two rising crossings are needed before the next `meas_valid`.
- With `SINE_WAVE_ANALYZER_AVG_EN`: raw periods 100, 100, 100, 104 → single `meas_valid` on the 4th measurement, `period`=101, `locked`=1 at that point.
